// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM states,
// response owner tags, the default fault instruction and the address check.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHARED = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_t;

  // addi x0, x0, 0 -- harmless filler returned for faulted fetches
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // A byte address faults when it is not word aligned or lies above the
  // last word of a memory with 2**aw words.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 32'd2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// slave: arbiter side. master: requesters plus memory side.
interface imem_arbiter_if #(
  parameter int ADDR_W = 7
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_we;
  logic              l_lock;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  logic              l_err;

  logic              cpu_halt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata, f_err,
    input  l_req, l_we, l_lock, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output cpu_halt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    output l_req, l_we, l_lock, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  cpu_halt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_addr_check.sv
// Converts a requester byte address into a word index and a fault flag.
module imem_addr_check
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic [31:0]       i_addr,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_fault
);

  assign o_index = i_addr[ADDR_W+1:2];
  assign o_fault = addr_fault(i_addr, ADDR_W);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between CPU fetch and the loader.
// Grants are combinational; the response owner/fault tag is registered and
// steers the one-cycle-late memory read data back to the right requester.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  owner_t            r_last;
  logic              r_cpu_halt;
  logic              r_rsp_valid;
  owner_t            r_rsp_owner;
  logic              r_rsp_fault;
  logic              r_rsp_we;

  logic [ADDR_W-1:0] w_f_index;
  logic              w_f_fault;
  logic [ADDR_W-1:0] w_l_index;
  logic              w_l_fault;
  logic              w_f_gnt;
  logic              w_l_gnt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0]       w_mem_wdata;
  logic              w_f_rvalid;
  logic              w_l_rvalid;

  imem_addr_check #(.ADDR_W(ADDR_W)) u_fetch_chk (
    .i_addr  (bus.f_addr),
    .o_index (w_f_index),
    .o_fault (w_f_fault)
  );

  imem_addr_check #(.ADDR_W(ADDR_W)) u_loader_chk (
    .i_addr  (bus.l_addr),
    .o_index (w_l_index),
    .o_fault (w_l_fault)
  );

  // Arbitration: loader owns the port while locked, otherwise round-robin on conflict
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (rst) begin
      w_f_gnt = 1'b0;
      w_l_gnt = 1'b0;
    end else if (r_state == ST_LOCKED) begin
      w_l_gnt = bus.l_req;
    end else if (bus.f_req && bus.l_req) begin
      if (r_last == OWN_LOADER) begin
        w_f_gnt = 1'b1;
      end else begin
        w_l_gnt = 1'b1;
      end
    end else begin
      w_f_gnt = bus.f_req;
      w_l_gnt = bus.l_req;
    end
  end

  // Memory port drive: only granted, non-faulting accesses reach the memory
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = 32'd0;
    if (w_l_gnt && !w_l_fault) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.l_we;
      w_mem_addr  = w_l_index;
      w_mem_wdata = bus.l_wdata;
    end else if (w_f_gnt && !w_f_fault) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b0;
      w_mem_addr  = w_f_index;
      w_mem_wdata = bus.l_wdata;
    end else begin
      w_mem_en    = 1'b0;
    end
  end

  // Ownership FSM, round-robin history, halt output and response tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= OWN_LOADER;
      r_cpu_halt  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWN_FETCH;
      r_rsp_fault <= 1'b0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_rsp_valid <= w_f_gnt | w_l_gnt;
      r_rsp_owner <= w_l_gnt ? OWN_LOADER : OWN_FETCH;
      r_rsp_fault <= (w_l_gnt & w_l_fault) | (w_f_gnt & w_f_fault);
      r_rsp_we    <= w_l_gnt & bus.l_we;
      if (w_l_gnt) begin
        r_last <= OWN_LOADER;
      end else if (w_f_gnt) begin
        r_last <= OWN_FETCH;
      end else begin
        r_last <= r_last;
      end
      case (r_state)
        ST_IDLE, ST_SHARED: begin
          if (w_l_gnt && bus.l_lock) begin
            r_state    <= ST_LOCKED;
            r_cpu_halt <= 1'b1;
          end else if (w_f_gnt || w_l_gnt) begin
            r_state    <= ST_SHARED;
            r_cpu_halt <= 1'b0;
          end else begin
            r_state    <= r_state;
            r_cpu_halt <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (!bus.l_lock) begin
            r_state    <= ST_SHARED;
            r_cpu_halt <= 1'b0;
          end else begin
            r_state    <= ST_LOCKED;
            r_cpu_halt <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cpu_halt <= 1'b0;
        end
      endcase
    end
  end

  assign w_f_rvalid = r_rsp_valid && (r_rsp_owner == OWN_FETCH);
  assign w_l_rvalid = r_rsp_valid && (r_rsp_owner == OWN_LOADER);

  assign bus.f_gnt     = w_f_gnt;
  assign bus.l_gnt     = w_l_gnt;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.cpu_halt  = r_cpu_halt;

  assign bus.f_rvalid = w_f_rvalid;
  assign bus.f_err    = w_f_rvalid & r_rsp_fault;
  assign bus.f_rdata  = !w_f_rvalid ? 32'd0 : (r_rsp_fault ? NOP_INST : bus.mem_rdata);

  assign bus.l_rvalid = w_l_rvalid;
  assign bus.l_err    = w_l_rvalid & r_rsp_fault;
  assign bus.l_rdata  = (w_l_rvalid && !r_rsp_fault && !r_rsp_we) ? bus.mem_rdata : 32'd0;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port arbiter and sequencer for the synchronous instruction memory, shared between the CPU fetch path and the program loader (UART boot/debug). Each cycle it grants at most one requester, drives the memory port, and routes the one-cycle-latency read data back to whichever requester issued the access. A lock mode gives the loader exclusive ownership for program download and holds the CPU off while it runs.

## Interface
Parameters:
- ADDR_W, 7, word-index width of the instruction memory (128 words)
- NOP_INST, 32'h00000013, data returned for faulted fetches

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch access request
- f_addr  in  32  fetch byte address (PC)
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  32  fetch read data
- f_err  out  1  fetch fault, qualified by f_rvalid
- l_req  in  1  loader access request
- l_we  in  1  loader write (1) / read (0)
- l_lock  in  1  loader requests exclusive ownership
- l_addr  in  32  loader byte address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader response valid (reads and writes)
- l_rdata  out  32  loader read data (0 for writes)
- l_err  out  1  loader fault, qualified by l_rvalid
- cpu_halt  out  1  high while loader holds the lock
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en

## Operation
- Word index = addr[ADDR_W+1:2]. Fault if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
- States: IDLE, SHARED, LOCKED. IDLE after reset; SHARED once any grant occurs; LOCKED entered when loader is granted with l_lock=1; LOCKED exits to SHARED on the first cycle l_lock=0.
- SHARED/IDLE arbitration: one requester -> granted. Both -> round-robin: grant the one not granted last; last_grant register resets to LOADER so fetch wins the first conflict.
- LOCKED: f_gnt forced 0; loader granted whenever l_req=1; cpu_halt=1.
- Granted, non-faulting: mem_en=1, mem_we=l_we (loader) or 0 (fetch), mem_addr=index, mem_wdata=l_wdata.
- Granted, faulting: mem_en=0 (no memory access, writes dropped); response still generated with err=1.
- Response: registered owner tag + fault flag; next cycle exactly one of f_rvalid/l_rvalid pulses. Fetch fault -> f_rdata=NOP_INST, f_err=1. Loader read fault -> l_rdata=0, l_err=1. Loader write -> l_rdata=0.
- Ungranted requesters hold request/address/data stable until gnt; arbiter does not queue.

## Timing
- Grant and mem_* combinational from requests and registered state; zero-cycle grant.
- Read latency 1 cycle: grant in cycle N -> rvalid/rdata in N+1. Back-to-back grants give one response per cycle.
- rdata outputs are mem_rdata muxed by the registered tag (no extra register).
- Reset values: f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err, cpu_halt, mem_en, mem_we = 0; f_rdata, l_rdata, mem_addr, mem_wdata = 0; state IDLE; tag cleared.
- Reset mid-access: pending response discarded, no rvalid after reset deasserts.
- cpu_halt asserts the cycle after the locking grant (registered from state) and deasserts the cycle after l_lock falls.
- l_lock rising while fetch is granted: fetch completes normally; lock takes effect on the next loader grant.

## Structure
- Shared package: state encoding (IDLE/SHARED/LOCKED), owner tag constants (OWN_FETCH/OWN_LOADER), NOP_INST default, fault-check function.
- One sub-module natural: imem_addr_check (byte address -> word index + fault bit), instantiated once per requester.
- Memory array stays outside; this block only drives its port.

## Test plan
- Fetch only, f_addr=0x8, mem[2]=0xDEADBEEF -> f_gnt same cycle, mem_addr=2, next cycle f_rvalid=1, f_rdata=0xDEADBEEF, f_err=0.
- Both request every cycle from reset -> grants alternate F,L,F,L; responses alternate one cycle later, no lost or duplicated rvalid.
- Loader l_lock=1, writes 0x00500093 to 0x0 then 0x00100113 to 0x4 -> cpu_halt=1 from cycle after first grant, f_gnt=0 throughout, drop l_lock -> cpu_halt=0 next cycle, fetch of 0x4 returns 0x00100113.
- Fetch f_addr=0x202 (misaligned) and 0x200 (out of range, ADDR_W=7) -> mem_en=0, f_rvalid=1, f_rdata=0x00000013, f_err=1.
- Loader write to 0x400 -> mem_en=0, l_rvalid=1, l_err=1; memory contents unchanged on readback.
- Assert rst the cycle after a fetch grant -> no f_rvalid after release, all outputs 0, next conflict granted to fetch.
